// File: rtl/sequential_divider.sv
// sequential_divider: 32-bit restoring shift-subtract divider (DIV/DIVU).
// One quotient bit per clock. Signed operands are reduced to magnitudes
// on entry, and the result signs are applied in a final SIGN cycle.
// All outputs are registered.
module sequential_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Q,
    output logic [31:0] R,
    output logic        dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] dvd_q, dvd_d;     // dividend magnitude, consumed MSB-first
    logic [31:0] dvs_q, dvs_d;     // divisor magnitude
    logic [31:0] quo_q, quo_d;     // quotient magnitude being built
    logic [32:0] rem_q, rem_d;     // partial remainder
    logic [4:0]  cnt_q, cnt_d;     // iteration counter 0..31
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] q_q, q_d;
    logic [31:0] r_q, r_d;
    logic        dz_q, dz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Operand magnitudes; sgn=0 passes the raw value through.
    logic [31:0] a_mag, b_mag;
    // One restoring step: shift in the next dividend bit, then trial-subtract.
    // The extra top bit of trial is the borrow (same decision as set-less-than).
    logic [32:0] rem_sh;
    logic [33:0] trial;
    logic        borrow;

    assign a_mag  = (sgn && A[31]) ? (~A + 32'd1) : A;
    assign b_mag  = (sgn && B[31]) ? (~B + 32'd1) : B;
    assign rem_sh = {rem_q[31:0], dvd_q[31]};
    assign trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign borrow = trial[33];

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (B == 32'd0) begin
                        // Divide by zero: skip the loop entirely.
                        q_d     = 32'hFFFF_FFFF;
                        r_d     = A;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        qneg_d  = sgn & (A[31] ^ B[31]);
                        rneg_d  = sgn & A[31];
                        rem_d   = 33'd0;
                        quo_d   = 32'd0;
                        cnt_d   = 5'd0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                dvd_d = {dvd_q[30:0], 1'b0};
                if (!borrow) begin
                    rem_d = trial[32:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_SIGN;
            end
            S_SIGN: begin
                // Overflow (0x80000000 / -1) needs nothing special: quo is
                // 0x80000000 with qneg=0, which is the wrapped result.
                q_d     = qneg_q ? (~quo_q + 32'd1) : quo_q;
                r_d     = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d == S_RUN) || (state_d == S_SIGN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            quo_q   <= 32'd0;
            rem_q   <= 33'd0;
            cnt_q   <= 5'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            q_q     <= 32'd0;
            r_q     <= 32'd0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign dz   = dz_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and random checks for sequential_divider.
module tb_sequential_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] A, B;
    logic        busy, done, dz;
    logic [31:0] Q, R;

    int checks = 0;
    int errors = 0;

    sequential_divider dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .sgn  (sgn),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .Q    (Q),
        .R    (R),
        .dz   (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: SV signed/unsigned division semantics.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Issue one operation and check results, latency (edge index of done
    // relative to the start edge) and busy cycle count. inj>0 pulses a
    // conflicting start that many edges into the operation.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int inj, input string tag);
        int lat, bcnt;
        @(negedge clk);
        A = a; B = b; sgn = s; start = 1'b1;
        @(posedge clk); #1;                  // edge 0
        start = 1'b0; A = $urandom; B = $urandom; sgn = ~s;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (inj != 0 && lat == inj) begin
                start = 1'b1; A = 32'd999; B = 32'd3; sgn = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "/done"}, 32'(done), 32'd1);
        chk({tag, "/lat"},  32'(lat),  edz ? 32'd0 : 32'd33);
        chk({tag, "/busy"}, 32'(bcnt), edz ? 32'd0 : 32'd33);
        chk({tag, "/Q"},    Q,  eq);
        chk({tag, "/R"},    R,  er);
        chk({tag, "/dz"},   32'(dz), 32'(edz));
        @(posedge clk); #1;                  // DONE -> IDLE
        chk({tag, "/pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, eq, er;
        logic        rs;
        int          n, lat;
        logic        seen;

        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/Q", Q, 32'd0);
        chk("rst/R", R, 32'd0);
        chk("rst/flags", {29'd0, busy, done, dz}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed operands with hand-computed results.
        do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 0, "u100_7");
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0, "sm7_2");
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 0, "s7_m2");
        do_div(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0, "dz");
        do_div(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 0, "dzclr");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 0, "sovf");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 0, "uovf");
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, "umax_1");

        // Start pulsed mid-operation is ignored.
        do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 10, "inject");

        // Start held through done: second op accepted at the first IDLE edge.
        @(negedge clk);
        A = 32'd100; B = 32'd7; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        A = 32'd1000; B = 32'd10;
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("held/lat1", 32'(lat), 32'd33);
        chk("held/Q1", Q, 32'd14);
        n = 0;
        while (!busy && n < 5) begin @(posedge clk); #1; n++; end
        chk("held/accept", 32'(busy), 32'd1);
        chk("held/gap", 32'(n), 32'd2);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("held/lat2", 32'(lat), 32'd33);
        chk("held/Q2", Q, 32'd100);
        chk("held/R2", R, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset during iteration 15.
        @(negedge clk);
        A = 32'd100; B = 32'd7; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst/Q", Q, 32'd0);
        chk("arst/R", R, 32'd0);
        chk("arst/flags", {29'd0, busy, done, dz}, 32'd0);
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        chk("arst/nodone", 32'(seen), 32'd0);
        do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 0, "arst/again");

        // Random signed and unsigned pairs against the reference model.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            if (i % 5 == 0) rb = rb >> ($urandom % 31);
            rs = 1'($urandom);
            ref_div(ra, rb, rs, eq, er);
            do_div(ra, rb, rs, eq, er, (rb == 32'd0), 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
